// File: rtl/read_chan_subo_param.sv
// read_chan_subo_param: read-side subordinate of the tiny AXI bus.
// AR requests are queued in a small FIFO and offered to the memory side.
// Each line returned by the memory side is replayed as a BEATS-beat R burst.
// An outstanding-read counter throttles arready.
//
// Handshakes (AR, R, memory request): a transfer occurs on a rising clk edge
// where valid and ready are both high; a raised valid keeps itself and its
// payload stable until that transfer, and no ready here is derived
// combinationally from the partner's valid.
module read_chan_subo_param #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LINE_W    = 128,
    parameter int REQ_DEPTH = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ID_W-1:0]                arid,
    input  logic [ADDR_W-1:0]              araddr,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [ID_W-1:0]                rid,
    output logic [DATA_W-1:0]              rdata,
    output logic                           rlast,
    output logic                           rreqc_s_valid,
    input  logic                           rreqc_s_ready,
    output logic [ID_W-1:0]                rreqc_s_id,
    output logic [ADDR_W-1:0]              rreqc_s_addr,
    input  logic                           rdata_s_valid,
    input  logic [ID_W-1:0]                rdata_s_id,
    input  logic [LINE_W-1:0]              rdata_s_data,
    output logic                           finish_rdata_s,
    output logic [$clog2(MAX_OUTST+1)-1:0] ostd_cnt
);

    localparam int BEATS  = LINE_W / DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam int AW     = $clog2(REQ_DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int ENT_W  = ID_W + ADDR_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ---------------- request FIFO ----------------
    logic [ENT_W-1:0] fifo_mem [REQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // arready looks only at registered state, so it can never loop back
    // through a manager that gates arvalid on arready.
    assign arready = !fifo_full && (ostd_cnt < CNT_W'(MAX_OUTST));
    assign push    = arvalid && arready;

    assign rreqc_s_valid = !fifo_empty;
    assign {rreqc_s_id, rreqc_s_addr} = fifo_mem[rd_ptr[AW-1:0]];
    assign pop = rreqc_s_valid && rreqc_s_ready;

    // Entry storage: written on push, no reset needed (read only when valid).
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {arid, araddr};
        end
    end

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // ---------------- outstanding counter ----------------
    logic last_hs;
    assign last_hs = rvalid && rready && rlast;

    // Count reads accepted on AR but not yet closed by an rlast transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ostd_cnt <= '0;
        end else begin
            case ({push, last_hs})
                2'b10:   ostd_cnt <= ostd_cnt + CNT_W'(1);
                2'b01:   ostd_cnt <= ostd_cnt - CNT_W'(1);
                default: ostd_cnt <= ostd_cnt;
            endcase
        end
    end

    // ---------------- R burst serializer ----------------
    logic [1:0]        state;
    logic [BEAT_W-1:0] beat;
    logic [LINE_W-1:0] line_q;
    logic [ID_W-1:0]   id_q;
    logic [LINE_W-1:0] line_shift;
    logic              beat_last;

    assign beat_last  = (beat == LAST_BEAT);
    assign line_shift = line_q >> (int'(beat) * DATA_W);

    // Outputs are forced to zero outside SEND so idle R lines stay quiet.
    assign rvalid         = (state == ST_SEND);
    assign rid            = rvalid ? id_q : '0;
    assign rdata          = rvalid ? line_shift[DATA_W-1:0] : '0;
    assign rlast          = rvalid && beat_last;
    assign finish_rdata_s = (state == ST_DONE);

    // Capture a line in IDLE, walk its beats lowest slice first, then signal DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            beat   <= '0;
            line_q <= '0;
            id_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rdata_s_valid) begin
                        line_q <= rdata_s_data;
                        id_q   <= rdata_s_id;
                        beat   <= '0;
                        state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rready) begin
                        if (beat_last) state <= ST_DONE;
                        else           beat  <= beat + BEAT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_chan_subo_param.sv
// Bench for read_chan_subo_param: instance a uses default parameters,
// instance b is a single-beat, two-outstanding variant. A queue-level model
// of both runs alongside and is compared every cycle; directed sequences add
// hand-computed literal expectations.
module tb_read_chan_subo_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- instance a signals ----------------
    logic         arvalid_a, arready_a, rvalid_a, rready_a, rlast_a;
    logic [3:0]   arid_a, rid_a, rq_id_a, ds_id_a;
    logic [31:0]  araddr_a, rdata_a, rq_addr_a;
    logic         rq_valid_a, rq_ready_a, ds_valid_a, finish_a;
    logic [127:0] ds_data_a;
    logic [2:0]   ostd_a;

    // ---------------- instance b signals ----------------
    logic         arvalid_b, arready_b, rvalid_b, rready_b, rlast_b;
    logic [3:0]   arid_b, rid_b, rq_id_b, ds_id_b;
    logic [31:0]  araddr_b, rdata_b, rq_addr_b;
    logic         rq_valid_b, rq_ready_b, ds_valid_b, finish_b;
    logic [31:0]  ds_data_b;
    logic [1:0]   ostd_b;

    read_chan_subo_param dut_a (
        .clk(clk), .rst(rst),
        .arvalid(arvalid_a), .arready(arready_a), .arid(arid_a), .araddr(araddr_a),
        .rvalid(rvalid_a), .rready(rready_a), .rid(rid_a), .rdata(rdata_a), .rlast(rlast_a),
        .rreqc_s_valid(rq_valid_a), .rreqc_s_ready(rq_ready_a),
        .rreqc_s_id(rq_id_a), .rreqc_s_addr(rq_addr_a),
        .rdata_s_valid(ds_valid_a), .rdata_s_id(ds_id_a), .rdata_s_data(ds_data_a),
        .finish_rdata_s(finish_a), .ostd_cnt(ostd_a)
    );

    read_chan_subo_param #(.LINE_W(32), .MAX_OUTST(2)) dut_b (
        .clk(clk), .rst(rst),
        .arvalid(arvalid_b), .arready(arready_b), .arid(arid_b), .araddr(araddr_b),
        .rvalid(rvalid_b), .rready(rready_b), .rid(rid_b), .rdata(rdata_b), .rlast(rlast_b),
        .rreqc_s_valid(rq_valid_b), .rreqc_s_ready(rq_ready_b),
        .rreqc_s_id(rq_id_b), .rreqc_s_addr(rq_addr_b),
        .rdata_s_valid(ds_valid_b), .rdata_s_id(ds_id_b), .rdata_s_data(ds_data_b),
        .finish_rdata_s(finish_b), .ostd_cnt(ostd_b)
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Request queue as a ring of entries, a count of open reads, and the
    // line currently being replayed (beat index into it).
    int           m_depth [2] = '{4, 4};
    int           m_max   [2] = '{4, 2};
    int           m_beats [2] = '{4, 1};
    logic [3:0]   mq_id   [2][4];
    logic [31:0]  mq_addr [2][4];
    int           mq_head [2];
    int           mq_size [2];
    int           m_cnt   [2];
    bit           m_send  [2];
    bit           m_done  [2];
    int           m_beat  [2];
    logic [127:0] m_line  [2];
    logic [3:0]   m_rid   [2];

    function automatic bit m_arready(input int k);
        return (mq_size[k] < m_depth[k]) && (m_cnt[k] < m_max[k]);
    endfunction

    task automatic model_step(input int k, input bit ar_v, input logic [3:0] ar_id,
                              input logic [31:0] ar_addr, input bit rq_rdy, input bit r_rdy,
                              input bit ds_v, input logic [3:0] ds_id, input logic [127:0] ds_data);
        bit ar_hs;
        bit last_hs;
        int slot;
        if (rst) begin
            mq_head[k] = 0; mq_size[k] = 0; m_cnt[k] = 0;
            m_send[k] = 1'b0; m_done[k] = 1'b0; m_beat[k] = 0;
            return;
        end
        ar_hs   = ar_v && m_arready(k);
        last_hs = m_send[k] && r_rdy && (m_beat[k] == m_beats[k] - 1);
        if (mq_size[k] > 0 && rq_rdy) begin
            mq_head[k] = (mq_head[k] + 1) % 4;
            mq_size[k]--;
        end
        if (ar_hs) begin
            slot = (mq_head[k] + mq_size[k]) % 4;
            mq_id[k][slot]   = ar_id;
            mq_addr[k][slot] = ar_addr;
            mq_size[k]++;
        end
        m_cnt[k] = m_cnt[k] + int'(ar_hs) - int'(last_hs);
        if (m_done[k]) begin
            m_done[k] = 1'b0;
        end else if (m_send[k]) begin
            if (r_rdy) begin
                if (last_hs) begin
                    m_send[k] = 1'b0;
                    m_done[k] = 1'b1;
                end else begin
                    m_beat[k]++;
                end
            end
        end else if (ds_v) begin
            m_line[k] = ds_data;
            m_rid[k]  = ds_id;
            m_beat[k] = 0;
            m_send[k] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, arvalid_a, arid_a, araddr_a, rq_ready_a, rready_a,
                   ds_valid_a, ds_id_a, ds_data_a);
        model_step(1, arvalid_b, arid_b, araddr_b, rq_ready_b, rready_b,
                   ds_valid_b, ds_id_b, {96'b0, ds_data_b});
    end

    task automatic cmp_inst(input int k, input string tag, input logic ar_rdy, input logic rv,
                            input logic [3:0] r_id, input logic [31:0] rd, input logic rl,
                            input logic rqv, input logic [3:0] rqid, input logic [31:0] rqaddr,
                            input logic fin, input logic [2:0] ostd);
        logic [127:0] sh;
        bit           e_last;
        sh     = m_line[k] >> (32 * m_beat[k]);
        e_last = m_send[k] && (m_beat[k] == m_beats[k] - 1);
        check({tag, ".arready"}, 64'(ar_rdy), 64'(m_arready(k)));
        check({tag, ".rvalid"}, 64'(rv), 64'(m_send[k]));
        check({tag, ".rlast"}, 64'(rl), 64'(e_last));
        check({tag, ".finish"}, 64'(fin), 64'(m_done[k]));
        check({tag, ".ostd_cnt"}, 64'(ostd), 64'(m_cnt[k]));
        check({tag, ".rreqc_valid"}, 64'(rqv), 64'(mq_size[k] > 0));
        if (m_send[k]) begin
            check({tag, ".rid"}, 64'(r_id), 64'(m_rid[k]));
            check({tag, ".rdata"}, 64'(rd), 64'(sh[31:0]));
        end
        if (mq_size[k] > 0) begin
            check({tag, ".rreqc_id"}, 64'(rqid), 64'(mq_id[k][mq_head[k]]));
            check({tag, ".rreqc_addr"}, 64'(rqaddr), 64'(mq_addr[k][mq_head[k]]));
        end
    endtask

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            cmp_inst(0, "a", arready_a, rvalid_a, rid_a, rdata_a, rlast_a,
                     rq_valid_a, rq_id_a, rq_addr_a, finish_a, ostd_a);
            cmp_inst(1, "b", arready_b, rvalid_b, rid_b, rdata_b, rlast_b,
                     rq_valid_b, rq_id_b, rq_addr_b, finish_b, {1'b0, ostd_b});
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] got_d [8];
    logic        got_l [8];
    logic [3:0]  got_id [8];
    int          got_n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a line to instance a and play rready from a repeating pattern
    // until the finish pulse appears; records every transferred beat.
    task automatic send_line_a(input string tag, input logic [3:0] id, input logic [127:0] data,
                               input logic [7:0] pat, input int plen);
        bit done;
        done  = 1'b0;
        got_n = 0;
        ds_valid_a = 1'b1;
        ds_id_a    = id;
        ds_data_a  = data;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            rready_a = pat[cyc % plen];
            if (finish_a) begin
                ds_valid_a = 1'b0;
                done = 1'b1;
            end else begin
                if (rvalid_a && rready_a && got_n < 8) begin
                    got_d[got_n]  = rdata_a;
                    got_l[got_n]  = rlast_a;
                    got_id[got_n] = rid_a;
                    got_n++;
                end
                tick();
            end
        end
        ds_valid_a = 1'b0;
        rready_a   = 1'b0;
        check({tag, ".finish_seen"}, 64'(done), 64'd1);
        tick();
        check({tag, ".finish_one_cycle"}, 64'(finish_a), 64'd0);
    endtask

    task automatic check_beats(input string tag, input logic [3:0] id, input logic [31:0] e0,
                               input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        check({tag, ".beat_count"}, 64'(got_n), 64'd4);
        for (int i = 0; i < 4 && i < got_n; i++) begin
            check({tag, ".beat_data"}, 64'(got_d[i]), 64'(e[i]));
            check({tag, ".beat_last"}, 64'(got_l[i]), 64'(i == 3));
            check({tag, ".beat_id"}, 64'(got_id[i]), 64'(id));
        end
    endtask

    task automatic push_ar_a(input logic [3:0] id, input logic [31:0] addr);
        arvalid_a = 1'b1; arid_a = id; araddr_a = addr;
        tick();
        arvalid_a = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        arvalid_a = 0; arid_a = 0; araddr_a = 0; rready_a = 0; rq_ready_a = 0;
        ds_valid_a = 0; ds_id_a = 0; ds_data_a = '0;
        arvalid_b = 0; arid_b = 0; araddr_b = 0; rready_b = 0; rq_ready_b = 0;
        ds_valid_b = 0; ds_id_b = 0; ds_data_b = '0;

        // Reset, then idle with reset values for 10 cycles.
        tick();
        check_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rst.arready", 64'(arready_a), 64'd1);
        check("rst.ostd", 64'(ostd_a), 64'd0);
        check("rst.rvalid", 64'(rvalid_a), 64'd0);
        check("rst.rlast", 64'(rlast_a), 64'd0);
        check("rst.rid", 64'(rid_a), 64'd0);
        check("rst.rdata", 64'(rdata_a), 64'd0);
        check("rst.rreqc_valid", 64'(rq_valid_a), 64'd0);
        check("rst.finish", 64'(finish_a), 64'd0);

        // Four back-to-back ARs with the memory side stalled.
        for (int i = 0; i < 4; i++) begin
            check("ar4.arready_before", 64'(arready_a), 64'd1);
            arvalid_a = 1'b1; arid_a = 4'(i + 1); araddr_a = 32'h100 + 32'(16 * i);
            tick();
        end
        arvalid_a = 1'b0;
        check("ar4.arready_dropped", 64'(arready_a), 64'd0);
        check("ar4.ostd", 64'(ostd_a), 64'd4);
        rq_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ar4.pop_valid", 64'(rq_valid_a), 64'd1);
            check("ar4.pop_id", 64'(rq_id_a), 64'(i + 1));
            check("ar4.pop_addr", 64'(rq_addr_a), 64'h100 + 64'(16 * i));
            tick();
        end
        rq_ready_a = 1'b0;
        check("ar4.fifo_empty", 64'(rq_valid_a), 64'd0);
        check("ar4.count_throttles", 64'(arready_a), 64'd0);

        // Full-rate burst.
        send_line_a("line5", 4'd5, 128'h44443333_22221111_DDDDCCCC_BBBBAAAA, 8'hFF, 1);
        check_beats("line5", 4'd5, 32'hBBBBAAAA, 32'hDDDDCCCC, 32'h22221111, 32'h44443333);
        check("line5.ostd", 64'(ostd_a), 64'd3);
        check("line5.arready", 64'(arready_a), 64'd1);

        // Stalled burst, rready pattern 1,0,0,1.
        send_line_a("line6", 4'd6, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 8'b0000_1001, 4);
        check_beats("line6", 4'd6, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);

        send_line_a("line7", 4'd7, 128'h1, 8'b0000_0110, 3);
        send_line_a("line8", 4'd8, 128'h2, 8'hFF, 1);
        check("drain.ostd", 64'(ostd_a), 64'd0);
        check("drain.arready", 64'(arready_a), 64'd1);

        // Instance b: two reads fill the count while the FIFO still has room.
        arvalid_b = 1'b1; arid_b = 4'd7; araddr_b = 32'h200;
        tick();
        arid_b = 4'd8; araddr_b = 32'h210;
        tick();
        check("b.arready_cnt_limit", 64'(arready_b), 64'd0);
        check("b.ostd_2", 64'(ostd_b), 64'd2);
        arid_b = 4'd9; araddr_b = 32'h2F0;
        tick(); tick();
        arvalid_b = 1'b0;
        check("b.ostd_still_2", 64'(ostd_b), 64'd2);
        rq_ready_b = 1'b1;
        tick(); tick();
        rq_ready_b = 1'b0;
        check("b.fifo_drained", 64'(rq_valid_b), 64'd0);

        ds_valid_b = 1'b1; ds_id_b = 4'd7; ds_data_b = 32'hCAFE0007; rready_b = 1'b1;
        tick();
        check("b.single_rvalid", 64'(rvalid_b), 64'd1);
        check("b.single_rlast", 64'(rlast_b), 64'd1);
        check("b.single_rdata", 64'(rdata_b), 64'hCAFE0007);
        check("b.single_rid", 64'(rid_b), 64'd7);
        tick();
        ds_valid_b = 1'b0;
        check("b.finish1", 64'(finish_b), 64'd1);
        check("b.ostd_1", 64'(ostd_b), 64'd1);
        check("b.arready_back", 64'(arready_b), 64'd1);
        tick();
        ds_valid_b = 1'b1; ds_id_b = 4'd8; ds_data_b = 32'hCAFE0008;
        tick();
        check("b.second_rlast", 64'(rlast_b), 64'd1);
        arvalid_b = 1'b1; arid_b = 4'd10; araddr_b = 32'h220;
        tick();
        arvalid_b = 1'b0; ds_valid_b = 1'b0; rready_b = 1'b0;
        check("b.ar_and_last_same_cycle", 64'(ostd_b), 64'd1);
        check("b.finish2", 64'(finish_b), 64'd1);
        tick();

        // Reset in the middle of a burst.
        push_ar_a(4'd3, 32'h300);
        ds_valid_a = 1'b1; ds_id_a = 4'd9; ds_data_a = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
        rready_a = 1'b1;
        tick(); tick(); tick();
        check("mid.rvalid_beat2", 64'(rvalid_a), 64'd1);
        check("mid.rdata_beat2", 64'(rdata_a), 64'hCCCCDDDD);
        rst = 1'b1; ds_valid_a = 1'b0; rready_a = 1'b0;
        tick();
        rst = 1'b0;
        check("mid.rvalid_cleared", 64'(rvalid_a), 64'd0);
        check("mid.no_finish", 64'(finish_a), 64'd0);
        check("mid.ostd_cleared", 64'(ostd_a), 64'd0);
        check("mid.fifo_cleared", 64'(rq_valid_a), 64'd0);
        tick();
        check("mid.no_finish_later", 64'(finish_a), 64'd0);

        push_ar_a(4'd10, 32'h400);
        send_line_a("fresh", 4'd10, 128'h0000000D_0000000C_0000000B_0000000A, 8'hFF, 1);
        check_beats("fresh", 4'd10, 32'hA, 32'hB, 32'hC, 32'hD);
        check("fresh.ostd", 64'(ostd_a), 64'd0);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound on the run.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
